// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and constants for the systolic skew feeder.
package systolic_skew_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    localparam int unsigned DEF_ARRAY_SIZE = 4;
    localparam int unsigned DEF_DATA_WIDTH = 4;

    // Width of a full lane vector (all lanes packed side by side).
    function automatic int unsigned lane_vec_w(input int unsigned lanes, input int unsigned width);
        return lanes * width;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_delay.sv
// skew_delay_line: per-lane shift register of DEPTH stages; output is the last stage.
module skew_delay_line #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] sr_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = din;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            sr_d[k] = sr_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonal-skew feeder for the systolic array: handshake in, lane i delayed i+1 cycles out.
// Optional beat counter output enabled by defining SKEW_BEAT_COUNT_EN.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE   = DEF_ARRAY_SIZE,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned FLUSH_CYCLES = 2 * ARRAY_SIZE - 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_last,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_act,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_wgt,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] activations,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] weights,
    output logic                             load,
    output logic                             acc_clear,
    output logic                             busy,
    output logic                             done
`ifdef SKEW_BEAT_COUNT_EN
    ,
    output logic [15:0]                      beat_count
`endif
);

    localparam int unsigned VEC_W = lane_vec_w(ARRAY_SIZE, DATA_WIDTH);
    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             load_q, load_d;
    logic             acc_clear_q, acc_clear_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic [VEC_W-1:0] inj_act, inj_wgt;

    assign accept  = in_valid && in_ready_q;
    assign inj_act = accept ? in_act : '0;
    assign inj_wgt = accept ? in_wgt : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            load_q      <= 1'b0;
            acc_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            load_q      <= load_d;
            acc_clear_q <= acc_clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (accept && in_last) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the upcoming state.
    always_comb begin
        in_ready_d  = (state_d == ST_STREAM);
        load_d      = (state_d != ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        acc_clear_d = (state_q == ST_IDLE) && start;
        done_d      = (state_d == ST_FLUSH) && (cnt_d == '0);
    end

    assign in_ready  = in_ready_q;
    assign load      = load_q;
    assign acc_clear = acc_clear_q;
    assign busy      = busy_q;
    assign done      = done_q;

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        skew_delay_line #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (i + 1)
        ) u_act (
            .clk  (clk),
            .reset(reset),
            .din  (inj_act[i*DATA_WIDTH +: DATA_WIDTH]),
            .dout (activations[i*DATA_WIDTH +: DATA_WIDTH])
        );

        skew_delay_line #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (i + 1)
        ) u_wgt (
            .clk  (clk),
            .reset(reset),
            .din  (inj_wgt[i*DATA_WIDTH +: DATA_WIDTH]),
            .dout (weights[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

`ifdef SKEW_BEAT_COUNT_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    // Cleared on the same edge that raises acc_clear, so beats in that cycle still count.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (acc_clear_d)                            beat_cnt_d = '0;
        else if (accept && (beat_cnt_q != 16'hFFFF)) beat_cnt_d = beat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) beat_cnt_q <= '0;
        else        beat_cnt_q <= beat_cnt_d;
    end

    assign beat_count = beat_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Table-driven bench for systolic_skew_feeder (4 lanes x 4 bits).
module tb_systolic_skew_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, in_valid, in_last;
    logic [15:0] in_act, in_wgt;
    logic        in_ready, load, acc_clear, busy, done;
    logic [15:0] activations, weights;
`ifdef SKEW_BEAT_COUNT_EN
    logic [15:0] beat_count;
`endif

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .ARRAY_SIZE  (4),
        .DATA_WIDTH  (4),
        .FLUSH_CYCLES(7)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_act     (in_act),
        .in_wgt     (in_wgt),
        .activations(activations),
        .weights    (weights),
        .load       (load),
        .acc_clear  (acc_clear),
        .busy       (busy),
        .done       (done)
`ifdef SKEW_BEAT_COUNT_EN
        ,
        .beat_count (beat_count)
`endif
    );

    typedef struct {
        logic        s, iv, il;
        logic [15:0] a, w;
        logic [4:0]  flags;   // {in_ready, load, acc_clear, busy, done}
        logic [15:0] ea, ew;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[35];

    logic [36:0] outs;
    assign outs = {in_ready, load, acc_clear, busy, done, activations, weights};

    function automatic logic [15:0] L(input logic [3:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input logic s, iv, il, input logic [15:0] a, w,
                                input logic [4:0] f, input logic [15:0] ea, ew);
        vec_t v;
        v.s = s; v.iv = iv; v.il = il; v.a = a; v.w = w;
        v.flags = f; v.ea = ea; v.ew = ew;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, iv, il, input logic [15:0] a, w);
        start = s; in_valid = iv; in_last = il; in_act = a; in_wgt = w;
    endtask

    localparam logic [4:0] F_SC = 5'b11110, F_S = 5'b11010, F_F = 5'b01010,
                           F_D  = 5'b01011, F_I = 5'b00000;

    initial begin
        // Tile A: four beats, start pulsed in STREAM and FLUSH, in_valid ignored in FLUSH.
        tbl[0]  = mk(1,0,0,16'h0000,16'h0000, F_SC, 16'h0, 16'h0);
        tbl[1]  = mk(0,1,0,16'h1111,16'h1111, F_S,  L(1,0,0,0), L(1,0,0,0));
        tbl[2]  = mk(1,1,0,16'h2222,16'h1111, F_S,  L(2,1,0,0), L(1,1,0,0));
        tbl[3]  = mk(0,1,0,16'h3333,16'h1111, F_S,  L(3,2,1,0), L(1,1,1,0));
        tbl[4]  = mk(0,1,1,16'h4444,16'h1111, F_F,  L(4,3,2,1), L(1,1,1,1));
        tbl[5]  = mk(0,0,0,16'h0000,16'h0000, F_F,  L(0,4,3,2), L(0,1,1,1));
        tbl[6]  = mk(1,1,0,16'h3333,16'h1111, F_F,  L(0,0,4,3), L(0,0,1,1));
        tbl[7]  = mk(0,0,0,16'h0000,16'h0000, F_F,  L(0,0,0,4), L(0,0,0,1));
        tbl[8]  = mk(0,0,0,16'h0000,16'h0000, F_F,  16'h0, 16'h0);
        tbl[9]  = mk(0,0,0,16'h0000,16'h0000, F_F,  16'h0, 16'h0);
        tbl[10] = mk(0,0,0,16'h0000,16'h0000, F_D,  16'h0, 16'h0);
        tbl[11] = mk(0,0,0,16'h0000,16'h0000, F_I,  16'h0, 16'h0);
        // Tile B: start the cycle after done with in_valid (not accepted), single beat -8/7.
        tbl[12] = mk(1,1,0,16'h5555,16'h5555, F_SC, 16'h0, 16'h0);
        tbl[13] = mk(0,1,1,16'h8888,16'h7777, F_F,  L(8,0,0,0), L(7,0,0,0));
        tbl[14] = mk(0,0,0,16'h0000,16'h0000, F_F,  L(0,8,0,0), L(0,7,0,0));
        tbl[15] = mk(0,0,0,16'h0000,16'h0000, F_F,  L(0,0,8,0), L(0,0,7,0));
        tbl[16] = mk(0,0,0,16'h0000,16'h0000, F_F,  L(0,0,0,8), L(0,0,0,7));
        tbl[17] = mk(0,0,0,16'h0000,16'h0000, F_F,  16'h0, 16'h0);
        tbl[18] = mk(0,0,0,16'h0000,16'h0000, F_F,  16'h0, 16'h0);
        tbl[19] = mk(0,0,0,16'h0000,16'h0000, F_D,  16'h0, 16'h0);
        tbl[20] = mk(0,0,0,16'h0000,16'h0000, F_I,  16'h0, 16'h0);
        // Tile C: two-cycle bubble between beats 2 and 3.
        tbl[21] = mk(1,0,0,16'h0000,16'h0000, F_SC, 16'h0, 16'h0);
        tbl[22] = mk(0,1,0,16'h1111,16'h1111, F_S,  L(1,0,0,0), L(1,0,0,0));
        tbl[23] = mk(0,1,0,16'h2222,16'h1111, F_S,  L(2,1,0,0), L(1,1,0,0));
        tbl[24] = mk(0,0,0,16'h0000,16'h0000, F_S,  L(0,2,1,0), L(0,1,1,0));
        tbl[25] = mk(0,0,0,16'h0000,16'h0000, F_S,  L(0,0,2,1), L(0,0,1,1));
        tbl[26] = mk(0,1,0,16'h3333,16'h1111, F_S,  L(3,0,0,2), L(1,0,0,1));
        tbl[27] = mk(0,1,1,16'h4444,16'h1111, F_F,  L(4,3,0,0), L(1,1,0,0));
        tbl[28] = mk(0,0,0,16'h0000,16'h0000, F_F,  L(0,4,3,0), L(0,1,1,0));
        tbl[29] = mk(0,0,0,16'h0000,16'h0000, F_F,  L(0,0,4,3), L(0,0,1,1));
        tbl[30] = mk(0,0,0,16'h0000,16'h0000, F_F,  L(0,0,0,4), L(0,0,0,1));
        tbl[31] = mk(0,0,0,16'h0000,16'h0000, F_F,  16'h0, 16'h0);
        tbl[32] = mk(0,0,0,16'h0000,16'h0000, F_F,  16'h0, 16'h0);
        tbl[33] = mk(0,0,0,16'h0000,16'h0000, F_D,  16'h0, 16'h0);
        tbl[34] = mk(0,0,0,16'h0000,16'h0000, F_I,  16'h0, 16'h0);

        rst_n = 1'b0;
        drive(0, 0, 0, 16'h0, 16'h0);
        #3;
        check("reset_state", 64'(outs), 64'd0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 35; i++) begin
            drive(tbl[i].s, tbl[i].iv, tbl[i].il, tbl[i].a, tbl[i].w);
            step();
            check($sformatf("row%0d", i), 64'(outs), 64'({tbl[i].flags, tbl[i].ea, tbl[i].ew}));
        end
        drive(0, 0, 0, 16'h0, 16'h0);

        // Reset asserted mid-STREAM after two beats.
        drive(1, 0, 0, 16'h0, 16'h0);
        step();
        drive(0, 1, 0, 16'h1111, 16'h1111);
        step();
        drive(0, 1, 0, 16'h2222, 16'h1111);
        step();
        check("pre_reset_stream", 64'(outs), 64'({F_S, L(2,1,0,0), L(1,1,0,0)}));
        drive(0, 0, 0, 16'h0, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", 64'(outs), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        begin
            int done_seen = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (done) done_seen++;
            end
            check("no_done_after_abort", 64'(done_seen), 64'd0);
            check("idle_after_abort", 64'({in_ready, load, busy}), 64'd0);
        end

`ifdef SKEW_BEAT_COUNT_EN
        begin
            bit found = 0;
            drive(1, 0, 0, 16'h0, 16'h0);
            step();
            for (int k = 0; k < 20; k++) begin
                drive(0, 1, (k == 19), 16'(k), 16'h1111);
                step();
            end
            drive(0, 0, 0, 16'h0, 16'h0);
            for (int i = 0; i < 20 && !found; i++) begin
                if (done) found = 1;
                else      step();
            end
            check("done_timeout", 64'(found), 64'd1);
            check("beat_count_at_done", 64'(beat_count), 64'd20);
            step(); step(); step();
            check("beat_count_hold", 64'(beat_count), 64'd20);
            drive(1, 0, 0, 16'h0, 16'h0);
            step();
            drive(0, 0, 0, 16'h0, 16'h0);
            check("beat_count_clear", 64'({acc_clear, beat_count}), 64'({1'b1, 16'd0}));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream feeder for the systolic array. Accepts one activation vector and one weight vector per beat over a valid/ready handshake.
- Applies the diagonal skew the array needs: lane i is delayed by i cycles. Drives the array's activations, weights and load inputs.
- After the last beat, flushes zeros until the array has drained, then pulses done.

Parameters:
- ARRAY_SIZE, 4, number of lanes (rows/cols of the array).
- DATA_WIDTH, 4, signed bits per element.
- FLUSH_CYCLES, 2*ARRAY_SIZE-1, zero-injection cycles after the last beat.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a tile.
- in_valid  in  1  input beat valid.
- in_ready  out  1  feeder accepts a beat this cycle.
- in_last  in  1  marks the final beat of the tile; qualified by in_valid&&in_ready.
- in_act  in  ARRAY_SIZE*DATA_WIDTH  activation vector; lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_wgt  in  ARRAY_SIZE*DATA_WIDTH  weight vector; same lane layout.
- activations  out  ARRAY_SIZE*DATA_WIDTH  skewed activations to the array.
- weights  out  ARRAY_SIZE*DATA_WIDTH  skewed weights to the array.
- load  out  1  array advance enable.
- acc_clear  out  1  one-cycle pulse to zero the array accumulators.
- busy  out  1  high in STREAM or FLUSH.
- done  out  1  one-cycle pulse at the end of FLUSH.

Behaviour:
- Reset (reset=0, asynchronous): all skew registers, activations, weights, load, acc_clear, busy, done and in_ready = 0; state = IDLE. Asserting reset mid-tile abandons the tile with no done pulse.
- Every output is registered.
- IDLE state:
  - in_ready=0, load=0, outputs hold 0.
  - start=1 -> STREAM next cycle. acc_clear=1 for exactly that first STREAM cycle.
- STREAM state:
  - in_ready=1, load=1, busy=1. The skew pipeline shifts every cycle.
  - On an accepted beat (in_valid&&in_ready), lane 0 of every shift chain takes the input element.
  - With no accepted beat, zeros are injected (bubble). Bubbles stay aligned across lanes and contribute 0 to every product.
  - Accepted beat with in_last=1 -> FLUSH; flush counter loads FLUSH_CYCLES-1.
  - start is ignored while busy.
- FLUSH state:
  - in_ready=0, load=1, zeros injected.
  - Counter decrements each cycle. At counter==0: done=1 for that cycle, load=1 for that final cycle, then IDLE next cycle.
- Skew: output lane i at cycle t equals the lane-i value injected at cycle t-1-i. Lane 0 latency is 1 cycle; lane ARRAY_SIZE-1 latency is ARRAY_SIZE cycles. Activation and weight chains are identical.
- Data is passed unmodified (signed, DATA_WIDTH). There is no arithmetic on the data path.
- A single-beat tile (in_last on the first beat) is legal.
- start and in_valid in the same IDLE cycle: the beat is not accepted (in_ready=0).

Optional Feature:
- Macro: SKEW_BEAT_COUNT_EN.
- Defined: adds output beat_count (16 bits). It clears on acc_clear, increments on each accepted beat, saturates at 16'hFFFF, and holds its value after done until the next tile starts.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package: state encoding constants (IDLE, STREAM, FLUSH) and a lane-slice width constant for ARRAY_SIZE*DATA_WIDTH.
- One natural sub-module, skew_delay_line: a per-lane DATA_WIDTH shift register of depth i+1 with async active-low reset. It is instantiated 2*ARRAY_SIZE times via generate.

Test Plan:
- Reset mid-STREAM: assert reset low after 2 beats -> all outputs 0 immediately; state IDLE; no done pulse.
- Single tile, 4 beats, act lanes = beat index k+1, wgt = 1, no bubbles:
  - acc_clear pulses on the first STREAM cycle.
  - Lane 0 shows 1,2,3,4 on cycles 1-4 after the first accept; lane 3 shows the same sequence 3 cycles later.
  - done occurs 7 cycles after the last accept; load high for the whole of STREAM and FLUSH.
- Bubbles: in_valid low for 2 cycles between beats 2 and 3 -> all lanes show a 2-cycle zero gap, staying diagonal.
- Single-beat tile with in_last=1 (act=-8 on all lanes, wgt=7) -> lane i shows -8/7 exactly once at i+1 cycles after the accept; done follows FLUSH_CYCLES cycles later.
- start pulsed during STREAM and FLUSH -> ignored; no second acc_clear. start on the cycle after done -> new tile begins.
- With SKEW_BEAT_COUNT_EN: a 20-beat tile -> beat_count=20 after done; count resets to 0 on the next acc_clear.
